// File: rtl/mem_arb_pkg.sv
// Shared types for the main-memory arbiter.
//   arb_state_t : arbiter FSM encoding
//   arb_owner_t : which requester owns the current transaction
//   ARB_TIMEOUT_W : width of the memory-wait watchdog counter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  localparam int ARB_TIMEOUT_W = 8;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between instruction fetch
// (I, read only) and the data cache (D, read or write). One transaction at a
// time; a watchdog aborts a transaction whose memory never acknowledges.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   i_req_i/i_addr_i        I-side read request and address
//   i_rdata_o/i_ack_o       I-side read data and one-cycle completion pulse
//   d_req_i/d_we_i/d_addr_i/d_wdata_i   D-side request, direction, address, data
//   d_rdata_o/d_ack_o       D-side read data and one-cycle completion pulse
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o   memory request side
//   mem_rdata_i/mem_ack_i   memory response side
//   err_o                   sticky watchdog timeout flag
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ARB_IDLE | no transaction; sample requests and grant one
// ARB_BUSY | mem_req_o high with latched fields, waiting for mem_ack_i
// ARB_RESP | one-cycle ack with latched read data to the owner
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_req_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic [DATA_WIDTH-1:0] i_rdata_o,
  output logic                  i_ack_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  d_ack_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic                  err_o
);

  // Abort fires on the BUSY cycle in which the counter would reach TIMEOUT,
  // so mem_req_o is high for exactly TIMEOUT cycles.
  localparam logic [ARB_TIMEOUT_W-1:0] TIMEOUT_LAST = ARB_TIMEOUT_W'(TIMEOUT - 1);

  arb_state_t              state_q, state_d;
  arb_owner_t              last_grant_q, last_grant_d;
  arb_owner_t              owner_q, owner_d;
  arb_owner_t              pick;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [ARB_TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                    err_q, err_d;
  logic                    i_ack_q, i_ack_d;
  logic                    d_ack_q, d_ack_d;
  logic [DATA_WIDTH-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;
  logic [DATA_WIDTH-1:0]   resp_data;
  logic                    finish;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    wait_cnt_d   = wait_cnt_q;
    err_d        = err_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    i_rdata_d    = '0;
    d_rdata_d    = '0;
    resp_data    = '0;
    finish       = 1'b0;

    // D wins when it is the only requester, or on a tie when I went last.
    pick = (d_req_i && (!i_req_i || last_grant_q == OWN_I)) ? OWN_D : OWN_I;

    case (state_q)
      ARB_IDLE: begin
        if (i_req_i || d_req_i) begin
          owner_d      = pick;
          last_grant_d = pick;
          mem_req_d    = 1'b1;
          wait_cnt_d   = '0;
          state_d      = ARB_BUSY;
          if (pick == OWN_D) begin
            mem_we_d    = d_we_i;
            mem_addr_d  = d_addr_i;
            mem_wdata_d = d_wdata_i;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = i_addr_i;
            mem_wdata_d = '0;
          end
        end
      end

      ARB_BUSY: begin
        if (mem_ack_i) begin
          finish    = 1'b1;
          resp_data = mem_we_q ? '0 : mem_rdata_i;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          finish    = 1'b1;
          err_d     = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end

        if (finish) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = ARB_RESP;
          if (owner_q == OWN_D) begin
            d_ack_d   = 1'b1;
            d_rdata_d = resp_data;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = resp_data;
          end
        end
      end

      ARB_RESP: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= OWN_I;
      owner_q      <= OWN_I;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wait_cnt_q   <= '0;
      err_q        <= 1'b0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      wait_cnt_q   <= wait_cnt_d;
      err_q        <= err_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign i_ack_o     = i_ack_q;
  assign d_ack_o     = d_ack_q;
  assign i_rdata_o   = i_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;

endmodule
